// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } sb_entry_t;

  localparam logic [6:0] OpcR    = 7'b0110011;
  localparam logic [6:0] OpcI    = 7'b0010011;
  localparam logic [6:0] OpcLoad = 7'b0000011;
  localparam logic [6:0] OpcS    = 7'b0100011;
  localparam logic [6:0] OpcB    = 7'b1100011;
  localparam logic [6:0] OpcJ    = 7'b1101111;

  // x0 is hardwired, so it never matches a pending write.
  function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] rs);
    return e.valid && (rs != 5'd0) && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode-side bundle between the control unit and hazard_ctrl.
interface hazard_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs1_in;
  logic [4:0]       rs2_in;
  logic             rs1_used_in;
  logic             rs2_used_in;
  logic [4:0]       rd_in;
  logic             rd_write_in;
  logic             is_load_in;
  logic             valid_in;
  logic             branch_taken_in;
  logic             stall_out;
  logic             flush_out;
  logic [1:0]       state_out;
  logic [CNT_W-1:0] stall_cnt_out;
  logic [CNT_W-1:0] flush_cnt_out;

  modport master (
    output rs1_in, rs2_in, rs1_used_in, rs2_used_in, rd_in, rd_write_in, is_load_in,
    output valid_in, branch_taken_in,
    input  stall_out, flush_out, state_out, stall_cnt_out, flush_cnt_out
  );

  modport slave (
    input  rs1_in, rs2_in, rs1_used_in, rs2_used_in, rd_in, rd_write_in, is_load_in,
    input  valid_in, branch_taken_in,
    output stall_out, flush_out, state_out, stall_cnt_out, flush_cnt_out
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register record of in-flight register writes with rs1/rs2 match flags.
// FORWARD_EN: only a load in the youngest entry counts as a hazard.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       issue_i,
  input  sb_entry_t  entry_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       rs1_hit_o,
  output logic       rs2_hit_o
);

  sb_entry_t entry_q [PIPE_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) entry_q[k] <= '0;
    end else begin
      entry_q[0] <= issue_i ? entry_i : '0;
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) entry_q[k] <= entry_q[k-1];
    end
  end

`ifdef FORWARD_EN
  // Bypass covers ALU results; only a load's data arrives too late.
  assign rs1_hit_o = entry_q[0].is_load && sb_hit(entry_q[0], rs1_i);
  assign rs2_hit_o = entry_q[0].is_load && sb_hit(entry_q[0], rs2_i);
`else
  always_comb begin
    rs1_hit_o = 1'b0;
    rs2_hit_o = 1'b0;
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      rs1_hit_o = rs1_hit_o | sb_hit(entry_q[k], rs1_i);
      rs2_hit_o = rs2_hit_o | sb_hit(entry_q[k], rs2_i);
    end
  end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Decode hazard/flush sequencer: RAW stall, taken-branch squash, perf counters.
// FORWARD_EN (passed to the scoreboard) restricts stalls to load-use.
module hazard_ctrl import hazard_pkg::*; #(
  parameter int unsigned PIPE_DEPTH   = 3,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic      req,
  input  logic      reset,
  hazard_if.slave   bus
);

  localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES);

  hazard_state_t    state_q;
  logic [2:0]       fcnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic      rs1_hit, rs2_hit;
  logic      hazard, stall, flush, issue;
  sb_entry_t entry_new;

  assign flush  = (state_q == StFlush);
  assign hazard = bus.valid_in &
                  ((bus.rs1_used_in & rs1_hit) | (bus.rs2_used_in & rs2_hit));
  assign stall  = hazard & ~flush;
  assign issue  = ~stall & ~flush;

  assign entry_new = '{valid:   bus.valid_in & bus.rd_write_in & (bus.rd_in != 5'd0),
                       rd:      bus.rd_in,
                       is_load: bus.is_load_in};

  hazard_scoreboard #(
    .PIPE_DEPTH (PIPE_DEPTH)
  ) u_scoreboard (
    .clk_i     (req),
    .rst_i     (reset),
    .issue_i   (issue),
    .entry_i   (entry_new),
    .rs1_i     (bus.rs1_in),
    .rs2_i     (bus.rs2_in),
    .rs1_hit_o (rs1_hit),
    .rs2_hit_o (rs2_hit)
  );

  always_ff @(posedge req) begin
    if (reset) begin
      state_q     <= StRun;
      fcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);

      // A taken branch outranks any hazard and restarts the squash window.
      if (bus.branch_taken_in) begin
        state_q <= StFlush;
        fcnt_q  <= FlushInit;
      end else begin
        case (state_q)
          StRun:   if (hazard) state_q <= StStall;
          StStall: if (!hazard) state_q <= StRun;
          StFlush: begin
            if (fcnt_q <= 3'd1) state_q <= StRun;
            else                fcnt_q  <= fcnt_q - 3'd1;
          end
          default: state_q <= StRun;
        endcase
      end
    end
  end

  assign bus.stall_out     = stall;
  assign bus.flush_out     = flush;
  assign bus.state_out     = state_q;
  assign bus.stall_cnt_out = stall_cnt_q;
  assign bus.flush_cnt_out = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: timestamp-based reference model plus directed
// sequences with literal expectations. Honours FORWARD_EN.
module tb_hazard_ctrl;

  localparam int PipeDepth   = 3;
  localparam int FlushCycles = 2;

`ifdef FORWARD_EN
  localparam int RawHeld = 0, LuHeld = 1, LuAluHeld = 0;
  localparam int RawCnt  = 0, LuCnt  = 1, BsCnt     = 2;
`else
  localparam int RawHeld = 3, LuHeld = 3, LuAluHeld = 3;
  localparam int RawCnt  = 3, LuCnt  = 9, BsCnt     = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) bus ();
  hazard_if #(.CNT_W(2))  sbus ();

  assign sbus.rs1_in          = bus.rs1_in;
  assign sbus.rs2_in          = bus.rs2_in;
  assign sbus.rs1_used_in     = bus.rs1_used_in;
  assign sbus.rs2_used_in     = bus.rs2_used_in;
  assign sbus.rd_in           = bus.rd_in;
  assign sbus.rd_write_in     = bus.rd_write_in;
  assign sbus.is_load_in      = bus.is_load_in;
  assign sbus.valid_in        = bus.valid_in;
  assign sbus.branch_taken_in = bus.branch_taken_in;

  hazard_ctrl #(.PIPE_DEPTH(PipeDepth), .FLUSH_CYCLES(FlushCycles), .CNT_W(16)) dut (
    .req   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Narrow-counter copy exercises saturation.
  hazard_ctrl #(.PIPE_DEPTH(PipeDepth), .FLUSH_CYCLES(FlushCycles), .CNT_W(2)) dut_sat (
    .req   (clk),
    .reset (rst),
    .bus   (sbus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: each issued write is remembered with its issue cycle.
  typedef struct {
    logic [4:0] rd;
    bit         ld;
    int         t;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  fend = -1;
  bit  prev_haz = 1'b0;
  bit  prev_flush = 1'b0;
  int  n_stall = 0;
  int  n_flush = 0;

  function automatic bit m_hazard();
    bit hit;
    bit live;
    int age;
    hit = 1'b0;
    if (!bus.valid_in) return 1'b0;
    foreach (wq[i]) begin
      age = cyc - wq[i].t;
`ifdef FORWARD_EN
      live = (age == 1) && wq[i].ld;
`else
      live = (age >= 1) && (age <= PipeDepth);
`endif
      if (live && bus.rs1_used_in && bus.rs1_in != 0 && bus.rs1_in == wq[i].rd) hit = 1'b1;
      if (live && bus.rs2_used_in && bus.rs2_in != 0 && bus.rs2_in == wq[i].rd) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic longint sat(input int n, input int w);
    return (n > (2 ** w) - 1) ? longint'((2 ** w) - 1) : longint'(n);
  endfunction

  always @(posedge clk) begin
    bit h, f, s;
    if (rst) begin
      wq.delete();
      fend = -1;
      prev_haz = 1'b0;
      prev_flush = 1'b0;
      n_stall = 0;
      n_flush = 0;
    end else begin
      h = m_hazard();
      f = (cyc <= fend);
      s = h && !f;
      if (!s && !f && bus.valid_in && bus.rd_write_in && bus.rd_in != 0)
        wq.push_back('{rd: bus.rd_in, ld: bus.is_load_in, t: cyc});
      if (s) n_stall++;
      if (f) n_flush++;
      if (bus.branch_taken_in) fend = cyc + FlushCycles;
      prev_haz = h;
      prev_flush = f;
    end
    cyc++;
  end

  always @(negedge clk) begin
    bit h, f;
    int est;
    if (chk_en) begin
      h = m_hazard();
      f = (cyc <= fend);
      est = f ? 2 : (prev_flush ? 0 : (prev_haz ? 1 : 0));
      chk("stall_out", bus.stall_out, h && !f);
      chk("flush_out", bus.flush_out, f);
      chk("state_out", bus.state_out, est);
      chk("stall_cnt", bus.stall_cnt_out, sat(n_stall, 16));
      chk("flush_cnt", bus.flush_cnt_out, sat(n_flush, 16));
      chk("sat_stall_cnt", sbus.stall_cnt_out, sat(n_stall, 2));
      chk("sat_flush_cnt", sbus.flush_cnt_out, sat(n_flush, 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int rd, input int rs1, input int rs2,
                        input bit u1, input bit u2, input bit wr, input bit ld, input bit br);
    bus.valid_in        = v;
    bus.rd_in           = 5'(rd);
    bus.rs1_in          = 5'(rs1);
    bus.rs2_in          = 5'(rs2);
    bus.rs1_used_in     = u1;
    bus.rs2_used_in     = u2;
    bus.rd_write_in     = wr;
    bus.is_load_in      = ld;
    bus.branch_taken_in = br;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  // Present one instruction until decode accepts it; held = cycles it waited.
  task automatic issue(input int rd, input int rs1, input int rs2, input bit u1, input bit u2,
                       input bit wr, input bit ld, output int held);
    bit go;
    held = 0;
    set_in(1, rd, rs1, rs2, u1, u2, wr, ld, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      go = !bus.stall_out && !bus.flush_out;
      tick();
      if (go) break;
      held++;
    end
    bus.valid_in = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    int h, hs;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_state", bus.state_out, 0);
    chk("rst_stall", bus.stall_out, 0);
    chk("rst_flush", bus.flush_out, 0);
    chk("rst_scnt", bus.stall_cnt_out, 0);
    chk("rst_fcnt", bus.flush_cnt_out, 0);
    tick();

    // addi x1; addi x2; add x3,x4,x5
    issue(1, 0, 0, 1, 0, 1, 0, h); hs = h;
    issue(2, 0, 0, 1, 0, 1, 0, h); hs += h;
    issue(3, 4, 5, 1, 1, 1, 0, h); hs += h;
    chk("indep_held", hs, 0);
    @(negedge clk);
    chk("indep_state", bus.state_out, 0);
    chk("indep_scnt", bus.stall_cnt_out, 0);
    tick();

    // add x5,x10,x11; sub x6,x5,x1
    idle(4);
    issue(5, 10, 11, 1, 1, 1, 0, h);
    issue(6, 5, 1, 1, 1, 1, 0, h);
    chk("raw_held", h, RawHeld);
    @(negedge clk);
    chk("raw_scnt", bus.stall_cnt_out, RawCnt);
    tick();

    // lw x7,0(x9); add x8,x7,x7; add x12,x8,x8
    idle(4);
    issue(7, 9, 0, 1, 0, 1, 1, h);
    issue(8, 7, 7, 1, 1, 1, 0, h);
    chk("lu_held", h, LuHeld);
    issue(12, 8, 8, 1, 1, 1, 0, h);
    chk("lu_alu_held", h, LuAluHeld);
    @(negedge clk);
    chk("lu_scnt", bus.stall_cnt_out, LuCnt);
    tick();

    // Single taken-branch pulse
    idle(4);
    bus.branch_taken_in = 1'b1;
    tick();
    bus.branch_taken_in = 1'b0;
    @(negedge clk);
    chk("br_flush_c1", bus.flush_out, 1);
    chk("br_state_c1", bus.state_out, 2);
    tick();
    @(negedge clk);
    chk("br_flush_c2", bus.flush_out, 1);
    tick();
    @(negedge clk);
    chk("br_flush_c3", bus.flush_out, 0);
    chk("br_state_c3", bus.state_out, 0);
    chk("br_fcnt", bus.flush_cnt_out, 2);
    tick();

    // lw x13; then a dependent op while branch resolves, second branch in flush cycle 1
    idle(2);
    issue(13, 0, 0, 1, 0, 1, 1, h);
    set_in(1, 14, 13, 0, 1, 0, 1, 0, 1);
    @(negedge clk);
    chk("bs_stall", bus.stall_out, 1);
    tick();
    @(negedge clk);
    chk("bs_state", bus.state_out, 2);
    chk("bs_stall_masked", bus.stall_out, 0);
    chk("bs_flush", bus.flush_out, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("bs_flush_c2", bus.flush_out, 1);
    tick();
    @(negedge clk);
    chk("bs_flush_c3", bus.flush_out, 1);
    tick();
    @(negedge clk);
    chk("bs_flush_end", bus.flush_out, 0);
    chk("bs_state_end", bus.state_out, 0);
    chk("bs_fcnt", bus.flush_cnt_out, 5);
    chk("bs_scnt", bus.stall_cnt_out, BsCnt);
    tick();

    // addi x0; add x1,x0,x0
    issue(0, 0, 0, 1, 0, 1, 0, h); hs = h;
    issue(1, 0, 0, 1, 1, 1, 0, h); hs += h;
    chk("x0_held", hs, 0);

    // lw x15; dependent op stalls, reset lands while in STALL
    idle(2);
    issue(15, 0, 0, 1, 0, 1, 1, h);
    set_in(1, 16, 15, 0, 1, 0, 1, 0, 0);
    @(negedge clk);
    chk("rs_stall", bus.stall_out, 1);
    tick();
    @(negedge clk);
    chk("rs_state_stall", bus.state_out, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rs_state", bus.state_out, 0);
    chk("rs_stall_out", bus.stall_out, 0);
    chk("rs_flush_out", bus.flush_out, 0);
    chk("rs_scnt", bus.stall_cnt_out, 0);
    chk("rs_fcnt", bus.flush_cnt_out, 0);
    tick();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
